// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared execute-stage constants and state encoding
// Purpose: state encoding and sizing constants for the sequential multiplier.
// Ports:   none (package).
package proc_pkg;

   localparam int MUL_W      = 8;
   localparam int MUL_CYCLES = 8;

   // 2'd3 is never entered; the FSM recovers it to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_DONE    = 2'd2,
      S_ILLEGAL = 2'd3
   } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - 8-bit ripple-carry adder
// Purpose: combinational sum = a + b + cin with carry out.
// Ports:   a[7:0], b[7:0], cin  -> sum[7:0], cout
module ripple_carry_adder
   import proc_pkg::*;
(
   input  logic [MUL_W-1:0] a,
   input  logic [MUL_W-1:0] b,
   input  logic             cin,
   output logic [MUL_W-1:0] sum,
   output logic             cout
);

   logic [MUL_W:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < MUL_W; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[MUL_W];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 8x8 unsigned shift-add multiplier, one step per clock
// Purpose: computes product = a * b over 8 clocks using one 8-bit adder.
// Ports:   clk, rst (sync, active-high)
//          start, a[7:0], b[7:0]     request and operands, sampled in IDLE/DONE
//          busy                      high while in RUN
//          done                      one-cycle pulse, product valid
//          product[15:0]             registered result, held until next completion
module seq_multiplier
   import proc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   // The adder is fixed at 8 bits, so any other width is rejected at elaboration.
   if (WIDTH != MUL_W || CNT_W != 3) begin : g_width_check
      $fatal(1, "seq_multiplier: WIDTH must be 8 and CNT_W must be 3");
   end

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mq;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic [2*WIDTH-1:0] step;
   logic               last_step;

   ripple_carry_adder u_add (
      .a    (acc),
      .b    (mq[0] ? mcand : '0),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // One shift-add step: the 17-bit {cout,sum,mq} shifted right by one.
   assign step      = {cout, sum, mq[WIDTH-1:1]};
   assign last_step = (cnt == CNT_W'(MUL_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_step) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         acc     <= '0;
         mq      <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mcand <= a;
                  mq    <= b;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               {acc, mq} <= step;
               cnt       <= cnt + CNT_W'(1);
               if (last_step) begin
                  product <= step;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);

endmodule
